// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and helpers for the cache/memory arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DFILL  = 3'd1,
    S_DWRITE = 3'd2,
    S_IFILL  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int c_blocksize_default = 4;

  // Width of the word-offset field within a block (log2 of words per block).
  function automatic int offset_width(input int bs);
    return (bs < 2) ? 1 : $clog2(bs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_fill_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fill_buffer
// Description : Block-fill word counter and fill-data assembly register.
// Revision    : 1.0  initial release
// ============================================================================
module fill_buffer
  import cache_pkg::*;
#(
  parameter int blocksize = c_blocksize_default
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear,
  input  logic                                load,
  input  logic [31:0]                         mrd,
  output logic [offset_width(blocksize)-1:0]  cnt,
  output logic                                last,
  output logic [blocksize*32-1:0]             fdata
);

  localparam int c_cw = offset_width(blocksize);
  localparam logic [c_cw-1:0] c_top = c_cw'(blocksize - 1);

  logic [c_cw-1:0]           r_cnt;
  logic [blocksize*32-1:0]   r_fdata;

  // Counter wraps naturally since blocksize is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Word 0 lands in the most significant slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fdata <= '0;
    end else if (load) begin
      for (int k = 0; k < blocksize; k++) begin
        if (r_cnt == c_cw'(k)) begin
          r_fdata[(blocksize-1-k)*32 +: 32] <= mrd;
        end
      end
    end
  end

  assign cnt   = r_cnt;
  assign last  = (r_cnt == c_top);
  assign fdata = r_fdata;

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Arbitrates I/D cache requests onto a single word-wide memory port.
// Revision    : 1.0  initial release
// ============================================================================
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int blocksize = c_blocksize_default
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dreq,
  input  logic                     dwe,
  input  logic [31:0]              da,
  input  logic [31:0]              dwd,
  input  logic                     ireq,
  input  logic [31:0]              ia,
  input  logic [31:0]              mrd,
  input  logic                     mready,
  output logic                     mreq,
  output logic                     mwe,
  output logic [31:0]              ma,
  output logic [31:0]              mwd,
  output logic [blocksize*32-1:0]  fdata,
  output logic                     ddone,
  output logic                     idone
);

  localparam int c_ow = offset_width(blocksize);

  state_t           r_state;
  state_t           w_next;
  logic [29:0]      r_addr;
  logic [31:0]      r_wd;
  logic             r_sel_d;
  logic             r_last_d;
  logic             w_grant;
  logic             w_grant_d;
  logic             w_load;
  logic             w_last;
  logic [c_ow-1:0]  w_cnt;
  logic             w_unused;

  assign w_unused = ^{da[1:0], ia[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Ties go to whoever was not served last; r_last_d=0 means I was last.
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dreq && (!ireq || !r_last_d)) begin
          w_grant   = 1'b1;
          w_grant_d = 1'b1;
          w_next    = dwe ? S_DWRITE : S_DFILL;
        end else if (ireq) begin
          w_grant = 1'b1;
          w_next  = S_IFILL;
        end
      end
      S_DFILL, S_IFILL: if (mready && w_last) w_next = S_DONE;
      S_DWRITE:         if (mready) w_next = S_DONE;
      S_DONE:           w_next = S_IDLE;
      default:          w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mreq   = 1'b0;
    mwe    = 1'b0;
    ma     = '0;
    mwd    = '0;
    ddone  = 1'b0;
    idone  = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_DFILL, S_IFILL: begin
        mreq   = 1'b1;
        ma     = {r_addr[29:c_ow], w_cnt, 2'b00};
        w_load = mready;
      end
      S_DWRITE: begin
        mreq = 1'b1;
        mwe  = 1'b1;
        ma   = {r_addr, 2'b00};
        mwd  = r_wd;
      end
      S_DONE: begin
        ddone = r_sel_d;
        idone = ~r_sel_d;
      end
      default: ;
    endcase
  end

  // Requester context is frozen at grant so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_wd     <= '0;
      r_sel_d  <= 1'b0;
      r_last_d <= 1'b0;
    end else if (w_grant) begin
      r_addr   <= w_grant_d ? da[31:2] : ia[31:2];
      r_wd     <= dwd;
      r_sel_d  <= w_grant_d;
      r_last_d <= w_grant_d;
    end
  end

  fill_buffer #(
    .blocksize (blocksize)
  ) u_fill_buffer (
    .clk   (clk),
    .reset (reset),
    .clear (w_grant),
    .load  (w_load),
    .mrd   (mrd),
    .cnt   (w_cnt),
    .last  (w_last),
    .fdata (fdata)
  );

endmodule
`default_nettype wire
